// File: rtl/day2_dff_variants.sv
// day2_dff_variants: single-clock D flip-flop variants for reset-style
// comparison. Outputs:
//   qnr   - plain flop, no reset
//   qsr   - flop with synchronous reset
//   qar   - synchronously reset flop whose output is also forced low by rst
//   adout - din delayed through an ADOUT_DEPTH-stage shift chain
// Optional feature macro: DAY2_QNR_INIT_EN
//   When defined, the no-reset flop gets a zero init value, which sets its
//   simulation start value and the FPGA configuration value.
//   When undefined, that flop is unknown until the first clock edge.
module day2_dff_variants #(
    parameter int WIDTH       = 1,
    parameter int ADOUT_DEPTH = 2   // legal range 1..8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] qnr,
    output logic [WIDTH-1:0] qsr,
    output logic [WIDTH-1:0] qar,
    output logic [WIDTH-1:0] adout
);

    // The no-reset flop is the only register that may carry an initialiser.
    // The other registers are defined by rst alone.
`ifdef DAY2_QNR_INIT_EN
    logic [WIDTH-1:0] r_qnr = '0;
`else
    logic [WIDTH-1:0] r_qnr;
`endif
    logic [WIDTH-1:0] r_qsr;
    logic [WIDTH-1:0] r_ar;
    logic [WIDTH-1:0] r_chain [ADOUT_DEPTH];

    // No-reset flop: captures din on every edge and ignores rst.
    always_ff @(posedge clk) begin
        r_qnr <= din;
    end

    // Synchronous-reset flop: rst wins over din at the edge.
    always_ff @(posedge clk) begin
        if (rst) r_qsr <= '0;
        else     r_qsr <= din;
    end

    // Backing register for qar. It uses the same rule as qsr.
    // It is kept separate so that the two paths stay independent.
    always_ff @(posedge clk) begin
        if (rst) r_ar <= '0;
        else     r_ar <= din;
    end

    // Delay chain: stage 0 takes din and each later stage takes the one before it.
    // A reset clears the whole chain, so adout reads 0 until fresh data has filled it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ADOUT_DEPTH; i++) r_chain[i] <= '0;
        end else begin
            r_chain[0] <= din;
            for (int i = 1; i < ADOUT_DEPTH; i++) r_chain[i] <= r_chain[i-1];
        end
    end

    // qar is gated combinationally by rst.
    // It therefore drops in the same cycle that rst rises, with no clock edge needed.
    always_comb begin
        qar = rst ? '0 : r_ar;
    end

    assign qnr   = r_qnr;
    assign qsr   = r_qsr;
    assign adout = r_chain[ADOUT_DEPTH-1];

endmodule

// File: tb/tb_day2_dff_variants.sv
// Directed bench for day2_dff_variants (WIDTH=1, ADOUT_DEPTH=2, 10-unit clock).
// Inputs change 1 unit after a rising edge, or at the falling edge for
// mid-cycle reset steps. Outputs are sampled 1 unit after a rising edge.
module tb_day2_dff_variants;

    logic clk = 1'b0;
    logic rst;
    logic din;
    logic qnr, qsr, qar, adout;

    int vectors    = 0;
    int miscompares = 0;

    day2_dff_variants #(.WIDTH(1), .ADOUT_DEPTH(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .qnr   (qnr),
        .qsr   (qsr),
        .qar   (qar),
        .adout (adout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] pat;
        logic       d1, d2;
        rst = 1'b1;
        din = 1'b0;
        #1;
`ifdef DAY2_QNR_INIT_EN
        chk("qnr_init", qnr, 1'b0);
`endif
        // Test 1: reset with din=0 for one edge.
        tick();
        chk("t1_qsr", qsr, 1'b0);
        chk("t1_qar", qar, 1'b0);
        chk("t1_adout", adout, 1'b0);
        chk("t1_qnr", qnr, 1'b0);

        // Test 2: release reset and apply din=1.
        rst = 1'b0; din = 1'b1;
        tick();
        chk("t2_qnr", qnr, 1'b1);
        chk("t2_qsr", qsr, 1'b1);
        chk("t2_qar", qar, 1'b1);
        chk("t2_adout_e1", adout, 1'b0);
        tick();
        chk("t2_adout_e2", adout, 1'b1);

        // Test 3: raise rst at the falling edge. qar clears immediately.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t3_qar_imm", qar, 1'b0);
        chk("t3_qsr_hold", qsr, 1'b1);
        chk("t3_adout_hold", adout, 1'b1);
        chk("t3_qnr_hold", qnr, 1'b1);
        tick();
        chk("t3_qsr_clr", qsr, 1'b0);
        chk("t3_adout_clr", adout, 1'b0);
        chk("t3_qar_clr", qar, 1'b0);
        chk("t3_qnr", qnr, 1'b1);

        // Test 4: hold rst for a second edge with din=1.
        tick();
        chk("t4_qsr", qsr, 1'b0);
        chk("t4_qar", qar, 1'b0);
        chk("t4_adout", adout, 1'b0);
        chk("t4_qnr", qnr, 1'b1);

        // Test 5: drop rst at the falling edge. qar shows the cleared r_ar until the next edge.
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_qar_mid", qar, 1'b0);
        tick();
        chk("t5_qsr", qsr, 1'b1);
        chk("t5_qar", qar, 1'b1);
        chk("t5_adout_e1", adout, 1'b0);
        tick();
        chk("t5_adout_e2", adout, 1'b1);

        // Test 6: toggle din. Expected values come from hand-tracked delay taps.
        pat = 8'b1011_0010;
        d1 = 1'b1;   // din captured at the previous edge
        for (int i = 0; i < 8; i++) begin
            din = pat[i];
            tick();
            d2 = d1;
            d1 = pat[i];
            chk($sformatf("t6_qnr_%0d", i), qnr, d1);
            chk($sformatf("t6_qsr_%0d", i), qsr, d1);
            chk($sformatf("t6_qar_%0d", i), qar, d1);
            chk($sformatf("t6_adout_%0d", i), adout, d2);
        end

        // Assert rst and change din in the same step. Reset wins everywhere except qnr.
        rst = 1'b1; din = ~din;
        tick();
        chk("sim_qnr", qnr, ~d1);
        chk("sim_qsr", qsr, 1'b0);
        chk("sim_qar", qar, 1'b0);
        chk("sim_adout", adout, 1'b0);

        // Release rst and confirm the chain refills from zero.
        rst = 1'b0; din = 1'b1;
        tick();
        chk("rel_qsr", qsr, 1'b1);
        chk("rel_adout_e1", adout, 1'b0);
        din = 1'b0;
        tick();
        chk("rel_adout_e2", adout, 1'b1);
        chk("rel_qar", qar, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
